sdram_write: RTL and testbench
==============================

SDRAM_WRITE -- requirements
Module: sdram_write

Interface
REQ-001 The block SHALL have parameter TRCD_CLK, default 2, meaning ACTIVE-to-WRITE wait in clocks.
REQ-002 The block SHALL have parameter TRP_CLK, default 2, meaning PRECHARGE-to-idle wait in clocks.
REQ-003 The block SHALL have input sys_clk, 1 bit: the single system clock, all logic on rising edge.
REQ-004 The block SHALL have input sys_rst_n, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input init_end, 1 bit: SDRAM initialisation done.
REQ-006 The block SHALL have input wr_en, 1 bit: write grant from arbiter, held until wr_end.
REQ-007 The block SHALL have input wr_addr_in, 21 bits: {bank[20:19], row[18:8], col[7:0]}.
REQ-008 The block SHALL have input wr_burst_len, 9 bits: words per burst, 1..256.
REQ-009 The block SHALL have input wr_data_in, 32 bits: write data from upstream FIFO, valid one clock after wr_ack.
REQ-010 The block SHALL have output wr_ack, 1 bit: upstream FIFO read strobe.
REQ-011 The block SHALL have output wr_end, 1 bit: one-clock pulse, burst complete.
REQ-012 The block SHALL have output wr_cmd, 4 bits: {cs_n, ras_n, cas_n, we_n}.
REQ-013 The block SHALL have output wr_ba, 2 bits: bank address.
REQ-014 The block SHALL have output wr_addr, 11 bits: SDRAM address bus.
REQ-015 The block SHALL have output wr_sdram_en, 1 bit: DQ drive enable.
REQ-016 The block SHALL have output wr_data, 32 bits: data for DQ.

Function
REQ-017 The FSM SHALL have states IDLE, ACTIVE, TRCD, WRITE, DATA, BSTOP, PRECH, TRP, END (one-hot).
REQ-018 IDLE->ACTIVE SHALL occur when init_end=1 and wr_en=1; wr_addr_in and wr_burst_len latched on that edge; latched length 0 treated as 1.
REQ-019 ACTIVE SHALL last 1 clock: wr_cmd=ACTIVE 0011, wr_ba=bank, wr_addr=row.
REQ-020 TRCD SHALL last TRCD_CLK clocks with wr_cmd=NOP 0111.
REQ-021 WRITE SHALL last 1 clock: wr_cmd=WRITE 0100, wr_ba=bank, wr_addr={3'b000,col} (full-page burst, no auto-precharge).
REQ-022 DATA SHALL last latched_len-1 clocks (skipped when len=1) with wr_cmd=NOP.
REQ-023 BSTOP SHALL last 1 clock: wr_cmd=BURST_STOP 0110.
REQ-024 PRECH SHALL last 1 clock: wr_cmd=PRECHARGE 0010, wr_addr[10]=1 (all banks).
REQ-025 TRP SHALL last TRP_CLK clocks with NOP; END SHALL last 1 clock with wr_end=1, then IDLE.
REQ-026 wr_ack SHALL be high for exactly latched_len clocks, beginning in the final TRCD clock.
REQ-027 wr_sdram_en SHALL be high for exactly latched_len clocks, from the WRITE clock through the last DATA clock; wr_data=wr_data_in combinationally.
REQ-028 Column counter SHALL wrap 255->0 within the row; bursts crossing a row end are caller error, not checked.
REQ-029 When not issuing a command: wr_cmd=0111, wr_ba=2'b11, wr_addr=11'h7ff.
REQ-030 wr_en falling mid-burst SHALL be ignored; a new burst needs wr_en=1 in IDLE.
REQ-031 Total latency wr_en-sample to wr_end = 1+TRCD_CLK+len+1+1+TRP_CLK clocks after ACTIVE entry.

Reset
REQ-032 On sys_rst_n=0 (any time, incl. mid-burst): state=IDLE, counters 0, wr_ack=0, wr_end=0, wr_sdram_en=0, wr_cmd=0111, wr_ba=2'b11, wr_addr=11'h7ff.

Structure
REQ-033 SDRAM command encodings (NOP, ACTIVE, WRITE, BURST_STOP, PRECHARGE) and address field widths SHALL live in the shared SDRAM package.
REQ-034 The block SHALL be flat; no sub-module.

Verification
REQ-035 wr_en=1, addr={2'd1,11'h05A,8'h10}, len=4, defaults -> ACTIVE ba=1 addr=0x05A; 2 NOP; WRITE addr=0x010; wr_sdram_en 4 clocks; BSTOP; PRECH addr=0x400; wr_end 11 clocks after ACTIVE.
REQ-036 len=1 -> DATA skipped, wr_ack and wr_sdram_en each exactly 1 clock, BSTOP the clock after WRITE.
REQ-037 len=256 col=0 -> 256 wr_ack pulses, 256 enable clocks, single WRITE command.
REQ-038 len=0 -> behaves as len=1.
REQ-039 sys_rst_n low during DATA beat 3 of len=8 -> next edge outputs NOP/0x7ff/ba 3, wr_sdram_en=0; new burst after reset completes normally.
REQ-040 init_end=0 with wr_en=1 -> no command issued, state stays IDLE.

Source files
------------

// File: rtl/sdram_write_pkg.sv
// rtl/sdram_write_pkg.sv - SDRAM command encodings, address field widths and write FSM states
//
// Contents:
//   CMD_*         4-bit SDRAM commands as {cs_n, ras_n, cas_n, we_n}
//   *_W           address field widths of the packed {bank, row, col} address
//   ADDR_IDLE     address bus value while no command is issued
//   ADDR_PRE_ALL  address bus value for PRECHARGE with A10 set (all banks)
//   wr_state_t    one-hot state encoding of the write sequencer

package sdram_write_pkg;

    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

    localparam int BA_W    = 2;
    localparam int ROW_W   = 11;
    localparam int COL_W   = 8;
    localparam int ADDR_W  = BA_W + ROW_W + COL_W;
    localparam int LEN_W   = 9;
    localparam int DATA_W  = 32;

    localparam logic [BA_W-1:0]  BA_IDLE      = 2'b11;
    localparam logic [ROW_W-1:0] ADDR_IDLE    = 11'h7ff;
    localparam logic [ROW_W-1:0] ADDR_PRE_ALL = 11'h400;

    typedef enum logic [8:0] {
        S_IDLE   = 9'b000000001,
        S_ACTIVE = 9'b000000010,
        S_TRCD   = 9'b000000100,
        S_WRITE  = 9'b000001000,
        S_DATA   = 9'b000010000,
        S_BSTOP  = 9'b000100000,
        S_PRECH  = 9'b001000000,
        S_TRP    = 9'b010000000,
        S_END    = 9'b100000000
    } wr_state_t;

endpackage

// File: rtl/sdram_write.sv
// rtl/sdram_write.sv - SDRAM full-page burst write sequencer
//
// Ports:
//   sys_clk, sys_rst_n   clock (rising edge), asynchronous active-low reset
//   init_end             SDRAM initialisation complete
//   wr_en                write grant from the arbiter, held until wr_end
//   wr_addr_in[20:0]     {bank[20:19], row[18:8], col[7:0]}
//   wr_burst_len[8:0]    words per burst (1..256, 0 treated as 1)
//   wr_data_in[31:0]     upstream FIFO data, valid the clock after wr_ack
//   wr_ack               upstream FIFO read strobe
//   wr_end               one-clock pulse when the burst sequence completes
//   wr_cmd[3:0]          {cs_n, ras_n, cas_n, we_n}
//   wr_ba[1:0]           bank address
//   wr_addr[10:0]        SDRAM address bus
//   wr_sdram_en          DQ output enable
//   wr_data[31:0]        data driven onto DQ

module sdram_write
    import sdram_write_pkg::*;
#(
    parameter int TRCD_CLK = 2,
    parameter int TRP_CLK  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [LEN_W-1:0]  wr_burst_len,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ack,
    output logic              wr_end,
    output logic [3:0]        wr_cmd,
    output logic [BA_W-1:0]   wr_ba,
    output logic [ROW_W-1:0]  wr_addr,
    output logic              wr_sdram_en,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [LEN_W-1:0] TRCD_LAST = LEN_W'(TRCD_CLK - 1);
    localparam logic [LEN_W-1:0] TRP_LAST  = LEN_W'(TRP_CLK - 1);

    wr_state_t          state;
    wr_state_t          next_state;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic [BA_W-1:0]    bank_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic               start;

    assign start = init_end && wr_en;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            len_q  <= '0;
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            state <= next_state;
            // cnt counts clocks spent in the current state; it restarts on every transition
            if (state != next_state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_IDLE && start) begin
                bank_q <= wr_addr_in[ADDR_W-1 -: BA_W];
                row_q  <= wr_addr_in[COL_W +: ROW_W];
                col_q  <= wr_addr_in[COL_W-1:0];
                len_q  <= (wr_burst_len == '0) ? LEN_W'(1) : wr_burst_len;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_ACTIVE;
            S_ACTIVE: next_state = S_TRCD;
            S_TRCD:   if (cnt == TRCD_LAST) next_state = S_WRITE;
            // the WRITE clock carries the first word, so DATA covers the remaining len-1
            S_WRITE:  next_state = (len_q == LEN_W'(1)) ? S_BSTOP : S_DATA;
            S_DATA:   if (cnt == len_q - LEN_W'(2)) next_state = S_BSTOP;
            S_BSTOP:  next_state = S_PRECH;
            S_PRECH:  next_state = S_TRP;
            S_TRP:    if (cnt == TRP_LAST) next_state = S_END;
            S_END:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register so an asynchronous reset
    // returns the bus to NOP immediately.
    always_comb begin
        wr_cmd      = CMD_NOP;
        wr_ba       = BA_IDLE;
        wr_addr     = ADDR_IDLE;
        wr_ack      = 1'b0;
        wr_sdram_en = 1'b0;
        wr_end      = 1'b0;
        case (state)
            S_ACTIVE: begin
                wr_cmd  = CMD_ACTIVE;
                wr_ba   = bank_q;
                wr_addr = row_q;
            end
            S_TRCD: begin
                // FIFO data lags wr_ack by one clock, so the first read leads WRITE
                wr_ack = (cnt == TRCD_LAST);
            end
            S_WRITE: begin
                wr_cmd      = CMD_WRITE;
                wr_ba       = bank_q;
                wr_addr     = {3'b000, col_q};
                wr_sdram_en = 1'b1;
                wr_ack      = (len_q > LEN_W'(1));
            end
            S_DATA: begin
                wr_sdram_en = 1'b1;
                // the last DATA clock needs no further read
                wr_ack      = (cnt < len_q - LEN_W'(2));
            end
            S_BSTOP: begin
                wr_cmd = CMD_BURST_STOP;
            end
            S_PRECH: begin
                wr_cmd  = CMD_PRECHARGE;
                wr_addr = ADDR_PRE_ALL;
            end
            S_END: begin
                wr_end = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign wr_data = wr_data_in;

endmodule

// File: tb/tb_sdram_write.sv
// tb/tb_sdram_write.sv - randomized self-checking bench for sdram_write

module tb_sdram_write;

    localparam int TRCD = 2;
    localparam int TRP  = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_end;
    logic        wr_en;
    logic [20:0] wr_addr_in;
    logic [8:0]  wr_burst_len;
    logic [31:0] wr_data_in;
    logic        wr_ack;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [10:0] wr_addr;
    logic        wr_sdram_en;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_write #(.TRCD_CLK(TRCD), .TRP_CLK(TRP)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .init_end     (init_end),
        .wr_en        (wr_en),
        .wr_addr_in   (wr_addr_in),
        .wr_burst_len (wr_burst_len),
        .wr_data_in   (wr_data_in),
        .wr_ack       (wr_ack),
        .wr_end       (wr_end),
        .wr_cmd       (wr_cmd),
        .wr_ba        (wr_ba),
        .wr_addr      (wr_addr),
        .wr_sdram_en  (wr_sdram_en),
        .wr_data      (wr_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, " cmd"}, 32'(wr_cmd), 32'h7);
        check({tag, " ba"}, 32'(wr_ba), 32'h3);
        check({tag, " addr"}, 32'(wr_addr), 32'h7ff);
        check({tag, " ack"}, 32'(wr_ack), 32'h0);
        check({tag, " en"}, 32'(wr_sdram_en), 32'h0);
        check({tag, " end"}, 32'(wr_end), 32'h0);
    endtask

    // One burst: timeline derived from phase lengths, words from a FIFO model.
    task automatic run_burst(input logic [20:0] addr, input logic [8:0] len_in, input int abort_c);
        int L;
        int t_wr;
        int t_bs;
        int t_pr;
        int t_end;
        int n;
        int rd_idx;
        int wr_cnt;
        int ack_cnt;
        logic [31:0] words[$];
        logic [3:0]  e_cmd;
        logic [1:0]  e_ba;
        logic [10:0] e_addr;
        logic        e_ack;
        logic        e_en;
        logic        pending;

        L      = (len_in == 0) ? 1 : int'(len_in);
        t_wr   = 1 + TRCD;
        t_bs   = t_wr + L;
        t_pr   = t_bs + 1;
        t_end  = t_pr + 1 + TRP;
        n      = t_end + 1;
        rd_idx = 0;
        wr_cnt = 0;
        ack_cnt = 0;
        for (int i = 0; i < L; i++) words.push_back($urandom);

        @(negedge sys_clk);
        init_end     = 1'b1;
        wr_en        = 1'b1;
        wr_addr_in   = addr;
        wr_burst_len = len_in;
        @(posedge sys_clk);
        #1;
        wr_en        = 1'($urandom_range(0, 1));
        wr_addr_in   = 21'($urandom);
        wr_burst_len = 9'($urandom);

        for (int c = 0; c < n; c++) begin
            @(negedge sys_clk);
            if (c == abort_c) begin
                wr_en = 1'b0;
                sys_rst_n = 1'b0;
                #1;
                check_idle_bus("async_reset");
                @(posedge sys_clk);
                #1;
                check_idle_bus("reset_hold");
                @(negedge sys_clk);
                sys_rst_n = 1'b1;
                return;
            end
            e_cmd  = 4'b0111;
            e_ba   = 2'b11;
            e_addr = 11'h7ff;
            if (c == 0) begin
                e_cmd = 4'b0011; e_ba = addr[20:19]; e_addr = addr[18:8];
            end else if (c == t_wr) begin
                e_cmd = 4'b0100; e_ba = addr[20:19]; e_addr = {3'b000, addr[7:0]};
            end else if (c == t_bs) begin
                e_cmd = 4'b0110;
            end else if (c == t_pr) begin
                e_cmd = 4'b0010; e_addr = 11'h400;
            end
            e_ack = (c >= t_wr - 1) && (c <= t_wr + L - 2);
            e_en  = (c >= t_wr) && (c <= t_wr + L - 1);
            check($sformatf("cmd c%0d", c), 32'(wr_cmd), 32'(e_cmd));
            check($sformatf("ba c%0d", c), 32'(wr_ba), 32'(e_ba));
            check($sformatf("addr c%0d", c), 32'(wr_addr), 32'(e_addr));
            check($sformatf("ack c%0d", c), 32'(wr_ack), 32'(e_ack));
            check($sformatf("en c%0d", c), 32'(wr_sdram_en), 32'(e_en));
            check($sformatf("end c%0d", c), 32'(wr_end), 32'(c == t_end));
            if (wr_cmd == 4'b0100) wr_cnt++;
            if (wr_ack) ack_cnt++;
            if (e_en) begin
                check($sformatf("data c%0d", c), wr_data, words[c - t_wr]);
            end
            pending = e_ack;
            @(posedge sys_clk);
            #1;
            if (pending) begin
                wr_data_in = words[rd_idx];
                rd_idx++;
            end else begin
                wr_data_in = $urandom;
            end
            wr_en = (c + 1 < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        check("write_cmds", 32'(wr_cnt), 32'd1);
        check("ack_total", 32'(ack_cnt), 32'(L));
        @(negedge sys_clk);
        check_idle_bus("post_burst");
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        init_end     = 1'b0;
        wr_en        = 1'b0;
        wr_addr_in   = '0;
        wr_burst_len = '0;
        wr_data_in   = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_idle_bus("reset");
        sys_rst_n = 1'b1;

        // no command while initialisation is incomplete
        wr_en = 1'b1;
        wr_addr_in = {2'd2, 11'h123, 8'h45};
        wr_burst_len = 9'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check_idle_bus("no_init");
        end
        wr_en = 1'b0;
        @(posedge sys_clk);
        #1;

        run_burst({2'd1, 11'h05A, 8'h10}, 9'd4, -1);
        run_burst({2'd3, 11'h7FF, 8'hFE}, 9'd1, -1);
        run_burst({2'd0, 11'h001, 8'h00}, 9'd0, -1);
        run_burst({2'd2, 11'h2A5, 8'h00}, 9'd256, -1);
        run_burst({2'd1, 11'h100, 8'h20}, 9'd2, -1);
        run_burst({2'd0, 11'h3C3, 8'h40}, 9'd8, 1 + TRCD + 3);
        run_burst({2'd2, 11'h0F0, 8'h08}, 9'd8, -1);
        for (int k = 0; k < 8; k++) begin
            run_burst(21'($urandom), 9'($urandom_range(0, 40)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
